// File: rtl/hazard_ctrl_unit.sv
// Hazard and stall controller for the 5-stage pipeline: load-use stall FSM, memory-wait freeze
// and taken-branch/jump flush. Define FWD_EN to enable EX-stage forwarding select.
module hazard_ctrl_unit #(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic [REG_AW-1:0] ex_wreg,
    input  logic              ex_regwr,
    input  logic              ex_memrd,
    input  logic              ex_branch,
    input  logic              ex_zf,
    input  logic              ex_jump,
    input  logic [REG_AW-1:0] mem_wreg,
    input  logic              mem_regwr,
    input  logic              mem_req,
    input  logic              mem_ready,
    input  logic [REG_AW-1:0] wb_wreg,
    input  logic              wb_regwr,
    output logic              pc_wr,
    output logic              pc_src,
    output logic              if_id_wr,
    output logic              if_id_clr,
    output logic              id_ex_wr,
    output logic              id_ex_clr,
    output logic              ex_ma_wr,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              stall
);

    typedef enum logic [1:0] {StRun, StLuStall, StMwait} st_e;

    localparam logic [CNT_W-1:0] LuInit = CNT_W'(LOAD_LAT - 1);

    st_e              st_q, st_d, ret_q, ret_d, eff_st;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_wait, taken, hazard, lu_count;
    logic [1:0]       fwd_a_sel, fwd_b_sel;

    assign mem_wait = mem_req & ~mem_ready;
    assign taken    = ex_jump | (ex_branch & ex_zf);
    // While frozen, behave as the state that was interrupted.
    assign eff_st   = (st_q == StMwait) ? ret_q : st_q;

`ifdef FWD_EN
    assign lu_count = (LOAD_LAT > 1);

    always_comb begin
        hazard = ex_memrd & ex_regwr & (ex_wreg != '0) &
                 ((ex_wreg == id_rs) | (id_uses_rt & (ex_wreg == id_rt)));
    end

    always_comb begin
        fwd_a_sel = 2'b00;
        if (mem_regwr && mem_wreg != '0 && mem_wreg == ex_rs) begin
            fwd_a_sel = 2'b10;
        end else if (wb_regwr && wb_wreg != '0 && wb_wreg == ex_rs) begin
            fwd_a_sel = 2'b01;
        end
    end

    always_comb begin
        fwd_b_sel = 2'b00;
        if (mem_regwr && mem_wreg != '0 && mem_wreg == ex_rt) begin
            fwd_b_sel = 2'b10;
        end else if (wb_regwr && wb_wreg != '0 && wb_wreg == ex_rt) begin
            fwd_b_sel = 2'b01;
        end
    end
`else
    logic rs_hit, rt_hit;
    logic unused_fwd_inputs;

    assign lu_count = 1'b0;

    // Full RAW interlock: any in-flight writer of an ID source holds the front end.
    always_comb begin
        rs_hit = (id_rs != '0) &
                 ((ex_regwr & (ex_wreg == id_rs)) | (mem_regwr & (mem_wreg == id_rs)));
        rt_hit = (id_rt != '0) &
                 ((ex_regwr & (ex_wreg == id_rt)) | (mem_regwr & (mem_wreg == id_rt)));
        hazard = rs_hit | (id_uses_rt & rt_hit);
    end

    assign fwd_a_sel = 2'b00;
    assign fwd_b_sel = 2'b00;
    assign unused_fwd_inputs = ^{ex_rs, ex_rt, wb_wreg, wb_regwr, ex_memrd};
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            st_q  <= StRun;
            ret_q <= StRun;
            cnt_q <= '0;
        end else begin
            st_q  <= st_d;
            ret_q <= ret_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        st_d  = st_q;
        ret_d = ret_q;
        cnt_d = cnt_q;
        if (mem_wait) begin
            st_d  = StMwait;
            ret_d = eff_st;
        end else if (taken) begin
            st_d  = StRun;
            cnt_d = '0;
        end else begin
            unique case (eff_st)
                StLuStall: begin
                    cnt_d = cnt_q - 1'b1;
                    st_d  = (cnt_q == 1) ? StRun : StLuStall;
                end
                default: begin
                    st_d = StRun;
                    if (hazard && lu_count) begin
                        st_d  = StLuStall;
                        cnt_d = LuInit;
                    end
                end
            endcase
        end
    end

    always_comb begin
        pc_wr     = 1'b1;
        pc_src    = 1'b0;
        if_id_wr  = 1'b1;
        if_id_clr = 1'b0;
        id_ex_wr  = 1'b1;
        id_ex_clr = 1'b0;
        ex_ma_wr  = 1'b1;
        fwd_a     = fwd_a_sel;
        fwd_b     = fwd_b_sel;
        stall     = 1'b0;
        if (!rst) begin
            pc_wr     = 1'b0;
            if_id_wr  = 1'b0;
            id_ex_wr  = 1'b0;
            ex_ma_wr  = 1'b0;
            if_id_clr = 1'b1;
            id_ex_clr = 1'b1;
            fwd_a     = 2'b00;
            fwd_b     = 2'b00;
        end else if (mem_wait) begin
            pc_wr    = 1'b0;
            if_id_wr = 1'b0;
            id_ex_wr = 1'b0;
            ex_ma_wr = 1'b0;
            stall    = 1'b1;
        end else if (taken) begin
            pc_src    = 1'b1;
            if_id_clr = 1'b1;
            id_ex_clr = 1'b1;
        end else if (eff_st == StLuStall || (eff_st == StRun && hazard)) begin
            pc_wr     = 1'b0;
            if_id_wr  = 1'b0;
            id_ex_clr = 1'b1;
            stall     = 1'b1;
        end
    end

endmodule
